// File: rtl/ltssm_substate_sequencer_if.sv
// Request/finish bundle between the LTSSM sequencer and its TX/RX sub-LTSSMs.
// The master side is the sequencer. The slave side is the link-control and sub-LTSSM environment.
interface ltssm_substate_sequencer_if;
    logic       enable;
    logic       retrain;
    logic       txFinish;
    logic       rxFinish;
    logic [3:0] rxExitTo;
    logic [3:0] substate;
    logic       reqTx;
    logic       reqRx;
    logic       forceDetect;
    logic       linkUp;
    logic       linkFail;
    logic [3:0] retryCount;

    modport master (
        input  enable, retrain, txFinish, rxFinish, rxExitTo,
        output substate, reqTx, reqRx, forceDetect, linkUp, linkFail, retryCount
    );

    modport slave (
        output enable, retrain, txFinish, rxFinish, rxExitTo,
        input  substate, reqTx, reqRx, forceDetect, linkUp, linkFail, retryCount
    );
endinterface

// File: rtl/ltssm_substate_sequencer.sv
// Walks the TX/RX sub-LTSSMs from detectQuiet to L0, one substate request at a time.
// Each request has a watchdog, and the link has a budget for consecutive failures.
module ltssm_substate_sequencer #(
    parameter int         WATCHDOG_CYCLES = 1024,
    parameter int         MAX_RETRIES     = 4,
    parameter logic [3:0] L0_CODE         = 4'd10
) (
    input logic                        clk,
    input logic                        reset,
    ltssm_substate_sequencer_if.master bus
);
    localparam int              WD_W      = $clog2(WATCHDOG_CYCLES);
    localparam logic [WD_W-1:0] WD_LAST   = WD_W'(WATCHDOG_CYCLES - 1);
    localparam logic [3:0]      MAX_LIMIT = 4'(MAX_RETRIES);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        DECIDE,
        FORCE,
        L0
    } SeqState;

    SeqState         state;
    logic            txDone;
    logic            rxDone;
    logic [3:0]      exitLatch;
    logic [WD_W-1:0] watchdog;

    logic       txDoneNow;
    logic       rxDoneNow;
    logic       bothDone;
    logic       exitIllegal;
    logic       decideFail;
    logic       goForce;
    logic       failNow;
    logic [3:0] bumpedCount;
    logic       budgetSpent;

    // The done check counts finishes arriving in the current cycle.
    // Completion therefore beats a watchdog expiry in the same cycle.
    always_comb begin
        txDoneNow   = txDone | bus.txFinish;
        rxDoneNow   = rxDone | bus.rxFinish;
        bothDone    = txDoneNow & rxDoneNow;
        exitIllegal = (exitLatch > L0_CODE) ||
                      ((exitLatch == 4'd0) && (bus.substate != 4'd0));
        decideFail  = (state == DECIDE) && (exitLatch != L0_CODE) && exitIllegal;
        goForce     = ((state == WAIT) && !bothDone && (watchdog == WD_LAST)) ||
                      ((state == L0) && bus.retrain);
        failNow     = decideFail | goForce;
        bumpedCount = (bus.retryCount == 4'hF) ? 4'hF : bus.retryCount + 4'd1;
        budgetSpent = (bumpedCount >= MAX_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            txDone          <= 1'b0;
            rxDone          <= 1'b0;
            exitLatch       <= 4'd0;
            watchdog        <= '0;
            bus.substate    <= 4'd0;
            bus.reqTx       <= 1'b0;
            bus.reqRx       <= 1'b0;
            bus.forceDetect <= 1'b0;
            bus.linkUp      <= 1'b0;
            bus.linkFail    <= 1'b0;
            bus.retryCount  <= 4'd0;
        end else if (!bus.enable) begin
            state           <= IDLE;
            txDone          <= 1'b0;
            rxDone          <= 1'b0;
            exitLatch       <= 4'd0;
            watchdog        <= '0;
            bus.substate    <= 4'd0;
            bus.reqTx       <= 1'b0;
            bus.reqRx       <= 1'b0;
            bus.forceDetect <= 1'b0;
            bus.linkUp      <= 1'b0;
            bus.linkFail    <= 1'b0;
            bus.retryCount  <= 4'd0;
        end else begin
            bus.reqTx       <= 1'b0;
            bus.reqRx       <= 1'b0;
            bus.forceDetect <= 1'b0;

            if (failNow) begin
                bus.retryCount <= bumpedCount;
                if (budgetSpent) begin
                    bus.linkFail <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (!bus.linkFail) begin
                        state        <= ISSUE;
                        bus.substate <= 4'd0;
                        bus.reqTx    <= 1'b1;
                        bus.reqRx    <= 1'b1;
                    end
                end

                ISSUE: begin
                    txDone   <= 1'b0;
                    rxDone   <= 1'b0;
                    watchdog <= '0;
                    state    <= WAIT;
                end

                WAIT: begin
                    watchdog <= watchdog + WD_W'(1);
                    if (bus.txFinish) begin
                        txDone <= 1'b1;
                    end
                    // Only the first RX finish of an attempt supplies the exit code.
                    if (bus.rxFinish && !rxDone) begin
                        rxDone    <= 1'b1;
                        exitLatch <= bus.rxExitTo;
                    end
                    if (bothDone) begin
                        state <= DECIDE;
                    end
                end

                DECIDE: begin
                    if (exitLatch == L0_CODE) begin
                        state          <= L0;
                        bus.linkUp     <= 1'b1;
                        bus.retryCount <= 4'd0;
                    end else if (decideFail) begin
                        if (budgetSpent) begin
                            state <= IDLE;
                        end else begin
                            state        <= ISSUE;
                            bus.substate <= 4'd0;
                            bus.reqTx    <= 1'b1;
                            bus.reqRx    <= 1'b1;
                        end
                    end else begin
                        state        <= ISSUE;
                        bus.substate <= exitLatch;
                        bus.reqTx    <= 1'b1;
                        bus.reqRx    <= 1'b1;
                    end
                end

                FORCE: begin
                    // forceDetect is the request here, so go back to WAIT without a new req pulse.
                    txDone   <= 1'b0;
                    rxDone   <= 1'b0;
                    watchdog <= '0;
                    state    <= bus.linkFail ? IDLE : WAIT;
                end

                L0: begin
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            if (goForce) begin
                state           <= FORCE;
                bus.forceDetect <= 1'b1;
                bus.substate    <= 4'd0;
                bus.linkUp      <= 1'b0;
                txDone          <= 1'b0;
                rxDone          <= 1'b0;
                watchdog        <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Scoreboard bench for ltssm_substate_sequencer. A stub TX/RX pair answers each request.
// A monitor matches every req/forceDetect pulse against the queued expectations.
module tb_ltssm_substate_sequencer;
    localparam int WD   = 16;
    localparam int MAXR = 4;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    ltssm_substate_sequencer_if bus();

    ltssm_substate_sequencer #(
        .WATCHDOG_CYCLES(WD),
        .MAX_RETRIES    (MAXR),
        .L0_CODE        (4'd10)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Each vector is {reqTx, reqRx, forceDetect, substate, retryCount, linkUp}.
    typedef struct {
        logic [11:0] vec;
        int          gap;
        string       name;
    } ExpEvent;

    ExpEvent expQ[$];
    ExpEvent monE;
    logic [11:0] monAct;

    int checkCount     = 0;
    int passCount      = 0;
    int cycle          = 0;
    int lastEventCycle = 0;

    int         txDelay;
    int         rxDelay;
    int         extraRxDelay;
    logic [3:0] extraRxCode;
    logic [3:0] exitTable [16];
    int         txCnt;
    int         rxCnt;
    int         rx2Cnt;
    logic [3:0] pendExit;
    logic [3:0] pendExtra;
    int         reqCount = 0;
    logic [3:0] lastReqSub = 4'd0;
    int         startCount;

    task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic rt);
        @(negedge clk);
        bus.enable  = en;
        bus.retrain = rt;
        if (rt) begin
            @(negedge clk);
            bus.retrain = 1'b0;
        end
    endtask

    function automatic void pushReq(input logic [3:0] sub, input logic [3:0] rc, input int gap);
        ExpEvent e;
        e.vec  = {3'b110, sub, rc, 1'b0};
        e.gap  = gap;
        e.name = $sformatf("req sub%0d rc%0d", sub, rc);
        expQ.push_back(e);
    endfunction

    function automatic void pushForce(input logic [3:0] rc, input int gap);
        ExpEvent e;
        e.vec  = {3'b001, 4'd0, rc, 1'b0};
        e.gap  = gap;
        e.name = $sformatf("forceDetect rc%0d", rc);
        expQ.push_back(e);
    endfunction

    function automatic void pushClimb(input int from, input int to, input logic [3:0] rc, input int firstGap);
        for (int s = from; s <= to; s++) begin
            pushReq(4'(s), rc, (s == from) ? firstGap : 5);
        end
    endfunction

    task automatic waitDrain(input string name, input int budget);
        int n;
        n = 0;
        while (expQ.size() > 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (expQ.size() > 0) begin
            checkCount++;
            $display("[TB] FAIL %s timeout: got %0d events pending, want 0", name, expQ.size());
            expQ.delete();
        end
        repeat (8) @(negedge clk);
    endtask

    task automatic waitReqAfter(input string name, input int start, input int sub, input int budget);
        int n;
        n = 0;
        while (!(reqCount > start && (sub < 0 || int'(lastReqSub) == sub)) && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!(reqCount > start && (sub < 0 || int'(lastReqSub) == sub))) begin
            checkCount++;
            $display("[TB] FAIL %s timeout: got no request, want request", name);
        end
    endtask

    // Stub TX/RX sub-LTSSMs: each answers a req or forceDetect after its programmed delay (0 = never).
    initial begin
        bus.txFinish = 1'b0;
        bus.rxFinish = 1'b0;
        bus.rxExitTo = 4'd0;
        txCnt = 0;
        rxCnt = 0;
        rx2Cnt = 0;
        pendExit = 4'd0;
        pendExtra = 4'd0;
        forever begin
            @(negedge clk);
            bus.txFinish = 1'b0;
            bus.rxFinish = 1'b0;
            bus.rxExitTo = 4'hE;
            if (reset) begin
                txCnt = 0;
                rxCnt = 0;
                rx2Cnt = 0;
            end else begin
                if (txCnt > 0) begin
                    txCnt--;
                    if (txCnt == 0) bus.txFinish = 1'b1;
                end
                if (rxCnt > 0) begin
                    rxCnt--;
                    if (rxCnt == 0) begin
                        bus.rxFinish = 1'b1;
                        bus.rxExitTo = pendExit;
                    end
                end
                if (rx2Cnt > 0) begin
                    rx2Cnt--;
                    if (rx2Cnt == 0) begin
                        bus.rxFinish = 1'b1;
                        bus.rxExitTo = pendExtra;
                    end
                end
                if (bus.reqTx || bus.forceDetect) begin
                    if (bus.reqTx) begin
                        reqCount++;
                        lastReqSub = bus.substate;
                    end
                    txCnt     = txDelay;
                    rxCnt     = rxDelay;
                    rx2Cnt    = extraRxDelay;
                    pendExit  = exitTable[bus.substate];
                    pendExtra = extraRxCode;
                end
            end
        end
    end

    // Monitor: every req or forceDetect pulse must match the head of the queue, including its spacing.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            if (!reset && (bus.reqTx || bus.reqRx || bus.forceDetect)) begin
                monAct = {bus.reqTx, bus.reqRx, bus.forceDetect, bus.substate, bus.retryCount, bus.linkUp};
                if (expQ.size() == 0) begin
                    checkCount++;
                    $display("[TB] FAIL unexpected event: got 0x%0h, want none", monAct);
                end else begin
                    monE = expQ.pop_front();
                    checkOutput(monE.name, 16'(monAct), 16'(monE.vec));
                    if (monE.gap >= 0) begin
                        checkOutput({monE.name, " gap"}, 16'(cycle - lastEventCycle), 16'(monE.gap));
                    end
                end
                lastEventCycle = cycle;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL global timeout: got still running, want finished");
        $fatal(1, "[TB] aborted");
    end

    initial begin
        reset        = 1'b1;
        bus.enable   = 1'b0;
        bus.retrain  = 1'b0;
        txDelay      = 3;
        rxDelay      = 3;
        extraRxDelay = 0;
        extraRxCode  = 4'd0;
        for (int s = 0; s < 16; s++) exitTable[s] = 4'd15;
        for (int s = 0; s < 9; s++) exitTable[s] = 4'(s + 1);
        exitTable[9] = 4'd10;

        repeat (3) @(negedge clk);
        checkOutput("reset substate", 16'(bus.substate), 16'd0);
        checkOutput("reset flags", 16'({bus.reqTx, bus.reqRx, bus.forceDetect, bus.linkUp, bus.linkFail}), 16'd0);
        checkOutput("reset retryCount", 16'(bus.retryCount), 16'd0);
        reset = 1'b0;

        $display("[TB] happy path");
        pushClimb(0, 9, 4'd0, -1);
        applyStimulus(1'b1, 1'b0);
        waitDrain("happy", 200);
        checkOutput("happy linkUp", 16'(bus.linkUp), 16'd1);
        checkOutput("happy retryCount", 16'(bus.retryCount), 16'd0);
        checkOutput("happy substate", 16'(bus.substate), 16'd9);
        checkOutput("happy linkFail", 16'(bus.linkFail), 16'd0);

        $display("[TB] retrain in L0");
        pushForce(4'd1, -1);
        pushClimb(1, 9, 4'd1, 5);
        applyStimulus(1'b1, 1'b1);
        waitDrain("retrain", 200);
        checkOutput("retrain linkUp", 16'(bus.linkUp), 16'd1);
        checkOutput("retrain retryCount", 16'(bus.retryCount), 16'd0);

        $display("[TB] async reset mid-WAIT");
        pushForce(4'd1, -1);
        pushReq(4'd1, 4'd1, 5);
        pushReq(4'd2, 4'd1, 5);
        pushReq(4'd3, 4'd1, 5);
        startCount = reqCount;
        applyStimulus(1'b1, 1'b1);
        waitReqAfter("reset setup", startCount, 3, 100);
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checkOutput("async reset substate", 16'(bus.substate), 16'd0);
        checkOutput("async reset retryCount", 16'(bus.retryCount), 16'd0);
        checkOutput("async reset flags", 16'({bus.reqTx, bus.reqRx, bus.forceDetect, bus.linkUp, bus.linkFail}), 16'd0);
        expQ.delete();
        @(negedge clk);
        #2 reset = 1'b0;
        pushClimb(0, 9, 4'd0, -1);
        waitDrain("post reset", 200);
        checkOutput("post reset linkUp", 16'(bus.linkUp), 16'd1);

        $display("[TB] finish skew");
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("disable linkUp", 16'(bus.linkUp), 16'd0);
        checkOutput("disable substate", 16'(bus.substate), 16'd0);
        txDelay      = 7;
        rxDelay      = 2;
        extraRxDelay = 4;
        extraRxCode  = 4'd7;
        pushReq(4'd0, 4'd0, -1);
        pushReq(4'd1, 4'd0, 9);
        pushClimb(2, 9, 4'd0, 5);
        startCount = reqCount;
        applyStimulus(1'b1, 1'b0);
        waitReqAfter("skew first req", startCount, -1, 50);
        txDelay      = 3;
        rxDelay      = 3;
        extraRxDelay = 0;
        waitDrain("skew", 200);
        checkOutput("skew linkUp", 16'(bus.linkUp), 16'd1);

        $display("[TB] watchdog");
        applyStimulus(1'b0, 1'b0);
        rxDelay = 0;
        pushReq(4'd0, 4'd0, -1);
        pushForce(4'd1, 17);
        pushClimb(1, 9, 4'd1, 5);
        startCount = reqCount;
        applyStimulus(1'b1, 1'b0);
        waitReqAfter("watchdog first req", startCount, -1, 50);
        repeat (5) @(negedge clk);
        rxDelay = 3;
        waitDrain("watchdog", 300);
        checkOutput("watchdog linkUp", 16'(bus.linkUp), 16'd1);
        checkOutput("watchdog retryCount", 16'(bus.retryCount), 16'd0);

        $display("[TB] retry budget");
        applyStimulus(1'b0, 1'b0);
        exitTable[2] = 4'd0;
        pushReq(4'd0, 4'd0, -1);
        pushReq(4'd1, 4'd0, 5);
        pushReq(4'd2, 4'd0, 5);
        for (int rc = 1; rc < MAXR; rc++) begin
            pushReq(4'd0, 4'(rc), 5);
            pushReq(4'd1, 4'(rc), 5);
            pushReq(4'd2, 4'(rc), 5);
        end
        applyStimulus(1'b1, 1'b0);
        waitDrain("retry budget", 300);
        repeat (30) @(negedge clk);
        checkOutput("budget linkFail", 16'(bus.linkFail), 16'd1);
        checkOutput("budget retryCount", 16'(bus.retryCount), 16'(MAXR));
        checkOutput("budget linkUp", 16'(bus.linkUp), 16'd0);
        applyStimulus(1'b0, 1'b0);
        @(negedge clk);
        checkOutput("toggle linkFail", 16'(bus.linkFail), 16'd0);
        checkOutput("toggle retryCount", 16'(bus.retryCount), 16'd0);
        exitTable[2] = 4'd3;
        pushClimb(0, 9, 4'd0, -1);
        applyStimulus(1'b1, 1'b0);
        waitDrain("after toggle", 200);
        checkOutput("after toggle linkUp", 16'(bus.linkUp), 16'd1);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
